// File: rtl/regfile_pkg.sv
// Shared register-file constants and writeback source indices.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned NUM_REGS   = 32;

  localparam int unsigned SRC_ALU    = 0;
  localparam int unsigned SRC_LOAD   = 1;
  localparam int unsigned SRC_MULDIV = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after last_grant.
module rr_arbiter #(
  parameter  int unsigned N     = 3,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant
);

  int unsigned idx;

  always_comb begin
    grant = '0;
    idx   = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(last_grant) + k) % N;
      if (grant == '0 && req[IDX_W'(idx)]) grant[IDX_W'(idx)] = 1'b1;
    end
  end

endmodule

// File: rtl/writeback_scheduler.sv
// Register-file write-port arbiter with per-register busy scoreboard for
// RAW/WAW hazard stalls at issue.
module writeback_scheduler
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned ADDR_W  = REG_ADDR_W,
  parameter int unsigned DATA_W  = REG_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_rs,
  input  logic [ADDR_W-1:0]         issue_rt,
  input  logic [ADDR_W-1:0]         issue_rd,
  input  logic                      issue_has_rd,
  output logic                      issue_stall,
  output logic                      RegWrite,
  output logic [ADDR_W-1:0]         writead,
  output logic [DATA_W-1:0]         data_in,
  output logic [NUM_REGS-1:0]       busy_mask
);

  localparam int unsigned    IDX_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_SRC - 1);

  logic [IDX_W-1:0]    last_grant;
  logic [NUM_SRC-1:0]  arb_grant;
  logic                any_grant;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic [IDX_W-1:0]    sel_idx;
  logic                wb_valid_q;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                set_en;

  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .req        (src_valid),
    .last_grant (last_grant),
    .grant      (arb_grant)
  );

  assign src_ready = reset ? '0 : arb_grant;
  assign any_grant = |src_ready;

  // Mux the single granted source onto the write stage inputs.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_idx  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (src_ready[i]) begin
        sel_addr = src_addr[i*ADDR_W +: ADDR_W];
        sel_data = src_data[i*DATA_W +: DATA_W];
        sel_idx  = IDX_W'(i);
      end
    end
  end

  assign issue_stall = ~reset & issue_valid &
                       (busy_q[issue_rs] | busy_q[issue_rt] | (issue_has_rd & busy_q[issue_rd]));
  assign set_en      = issue_valid & ~issue_stall & issue_has_rd & (issue_rd != '0);

  // Clear on the committing write, set on accepted issue; they never hit the same bit.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid_q) busy_d[writead] = 1'b0;
    if (set_en)     busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      writead    <= '0;
      data_in    <= '0;
      busy_q     <= '0;
      last_grant <= LAST_RST;
    end else begin
      wb_valid_q <= any_grant && (sel_addr != '0);
      busy_q     <= busy_d;
      if (any_grant) begin
        writead    <= sel_addr;
        data_in    <= sel_data;
        last_grant <= sel_idx;
      end
    end
  end

  assign RegWrite  = wb_valid_q;
  assign busy_mask = busy_q;

endmodule

// File: tb/tb_writeback_scheduler.sv
// Randomized bench for writeback_scheduler against a queue-free behavioural
// model of round-robin grants, write stage, scoreboard and register file.
module tb_writeback_scheduler;
  import regfile_pkg::*;

  localparam int unsigned NS = 3;
  localparam int unsigned AW = REG_ADDR_W;
  localparam int unsigned DW = REG_DATA_W;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NS-1:0]        src_valid, src_ready;
  logic [NS*AW-1:0]     src_addr;
  logic [NS*DW-1:0]     src_data;
  logic                 issue_valid, issue_has_rd, issue_stall;
  logic [AW-1:0]        issue_rs, issue_rt, issue_rd;
  logic                 RegWrite;
  logic [AW-1:0]        writead;
  logic [DW-1:0]        data_in;
  logic [NUM_REGS-1:0]  busy_mask;

  always #5 clk = ~clk;

  writeback_scheduler #(.NUM_SRC(NS), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .src_addr     (src_addr),
    .src_data     (src_data),
    .issue_valid  (issue_valid),
    .issue_rs     (issue_rs),
    .issue_rt     (issue_rt),
    .issue_rd     (issue_rd),
    .issue_has_rd (issue_has_rd),
    .issue_stall  (issue_stall),
    .RegWrite     (RegWrite),
    .writead      (writead),
    .data_in      (data_in),
    .busy_mask    (busy_mask)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Register file as the DUT drives it (no reset, like the real array).
  logic [DW-1:0] rf [NUM_REGS];
  always @(posedge clk) if (RegWrite === 1'b1) rf[writead] <= data_in;

  // Reference model state.
  int              m_last;
  logic [31:0]     m_busy;
  logic            m_wb;
  logic [AW-1:0]   m_wa;
  logic [DW-1:0]   m_wd;
  logic [DW-1:0]   m_rf [NUM_REGS];
  int              last_g;

  function automatic int exp_grant();
    if (reset) return -1;
    for (int k = 1; k <= int'(NS); k++) begin
      int i;
      i = (m_last + k) % int'(NS);
      if (src_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_src(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    src_valid[i]          = v;
    src_addr[i*AW +: AW]  = a;
    src_data[i*DW +: DW]  = d;
  endtask

  // Check one cycle against the model, then advance the model across the edge.
  task automatic step(input string tag);
    int            g;
    logic          st;
    logic [NS-1:0] er;
    g  = exp_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    st = !reset && issue_valid &&
         (m_busy[issue_rs] || m_busy[issue_rt] || (issue_has_rd && m_busy[issue_rd]));
    #1;
    check({tag, ".ready"}, 64'(src_ready), 64'(er));
    check({tag, ".stall"}, 64'(issue_stall), 64'(st));
    check({tag, ".regwrite"}, 64'(RegWrite), 64'(m_wb));
    check({tag, ".busy"}, 64'(busy_mask), 64'(m_busy));
    if (m_wb) begin
      check({tag, ".writead"}, 64'(writead), 64'(m_wa));
      check({tag, ".data_in"}, 64'(data_in), 64'(m_wd));
    end
    @(posedge clk);
    if (m_wb) m_rf[m_wa] = m_wd;
    if (reset) begin
      m_wb = 1'b0; m_wa = '0; m_wd = '0; m_busy = '0; m_last = NS - 1;
    end else begin
      if (m_wb) m_busy[m_wa] = 1'b0;
      if (issue_valid && !st && issue_has_rd && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      m_wb = 1'b0;
      if (g >= 0) begin
        m_wa   = src_addr[g*AW +: AW];
        m_wd   = src_data[g*DW +: DW];
        m_wb   = (m_wa != 0);
        m_last = g;
      end
    end
    last_g = g;
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] hd;
    for (int r = 0; r < int'(NUM_REGS); r++) begin rf[r] = '0; m_rf[r] = '0; end
    m_busy = '0; m_wb = 1'b0; m_wa = '0; m_wd = '0; m_last = NS - 1; last_g = -1;

    // Reset held two cycles with everything requesting.
    reset = 1'b1;
    issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rs = 5'd1; issue_rt = 5'd2; issue_rd = 5'd3;
    for (int i = 0; i < int'(NS); i++) set_src(i, 1'b1, AW'(i + 1), DW'(32'hA0 + i));
    #1;
    check("rst0.ready", 64'(src_ready), 64'(0));
    check("rst0.stall", 64'(issue_stall), 64'(0));
    @(posedge clk);
    @(negedge clk);
    step("rst1");
    #1;
    check("rst.writead", 64'(writead), 64'(0));
    check("rst.data_in", 64'(data_in), 64'(0));
    reset = 1'b0; issue_valid = 1'b0; src_valid = '0;

    // Single write from the ALU.
    set_src(SRC_ALU, 1'b1, 5'd5, 32'hDEADBEEF);
    #1 check("single.ready", 64'(src_ready), 64'(3'b001));
    step("single_t");
    src_valid = '0;
    #1;
    check("single.we", 64'(RegWrite), 64'(1));
    check("single.addr", 64'(writead), 64'(5));
    check("single.data", 64'(data_in), 64'(32'hDEADBEEF));
    step("single_t1");
    #1 check("single.we_off", 64'(RegWrite), 64'(0));
    step("single_t2");

    // Contention: last grant was src0, so rotation starts at src1.
    for (int i = 0; i < int'(NS); i++) set_src(i, 1'b1, AW'(i + 1), $urandom);
    for (int k = 0; k < 6; k++) begin
      logic [NS-1:0] eg;
      eg = 3'b001 << ((k + 1) % 3);
      #1 check("contend.grant", 64'(src_ready), 64'(eg));
      step("contend");
    end
    src_valid = '0;
    step("contend_drain");

    // Hazard on r7 released by a load writeback.
    issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd7; issue_rs = '0; issue_rt = '0;
    step("haz_t");
    issue_rs = 5'd7; issue_has_rd = 1'b0;
    #1;
    check("haz.busy7", 64'(busy_mask[7]), 64'(1));
    check("haz.stall_t1", 64'(issue_stall), 64'(1));
    step("haz_t1");
    step("haz_t2");
    hd = $urandom;
    set_src(SRC_LOAD, 1'b1, 5'd7, hd);
    #1;
    check("haz.stall_t3", 64'(issue_stall), 64'(1));
    check("haz.grant_t3", 64'(src_ready), 64'(3'b010));
    step("haz_t3");
    src_valid = '0;
    #1 check("haz.stall_t4", 64'(issue_stall), 64'(1));
    step("haz_t4");
    #1;
    check("haz.stall_t5", 64'(issue_stall), 64'(0));
    check("haz.rf7", 64'(rf[7]), 64'(hd));
    issue_valid = 1'b0;
    step("haz_t5");

    // Register zero is never marked busy and never written.
    issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = '0; issue_rs = '0; issue_rt = '0;
    step("zero_issue");
    issue_valid = 1'b0;
    #1 check("zero.busy", 64'(busy_mask), 64'(0));
    set_src(SRC_MULDIV, 1'b1, '0, 32'h12345678);
    #1 check("zero.ready", 64'(src_ready), 64'(3'b100));
    step("zero_wr");
    src_valid = '0;
    for (int k = 0; k < 3; k++) begin
      #1 check("zero.we", 64'(RegWrite), 64'(0));
      step("zero_after");
    end

    // Reset in the middle of traffic.
    issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rs = '0; issue_rt = '0; issue_rd = 5'd3;
    step("mid_rd3");
    issue_rd = 5'd9;
    step("mid_rd9");
    issue_valid = 1'b0;
    for (int i = 0; i < int'(NS); i++) set_src(i, 1'b1, AW'(20 + i), $urandom);
    #1 check("mid.busy_pre", 64'(busy_mask), 64'(32'h0000_0208));
    reset = 1'b1;
    step("mid_rst");
    reset = 1'b0;
    #1;
    check("mid.busy", 64'(busy_mask), 64'(0));
    check("mid.we", 64'(RegWrite), 64'(0));
    check("mid.first_grant", 64'(src_ready), 64'(3'b001));

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 2000; n++) begin
      reset        = ($urandom_range(0, 199) == 0);
      issue_valid  = $urandom_range(0, 1) == 1;
      issue_has_rd = $urandom_range(0, 3) != 0;
      issue_rs     = AW'($urandom_range(0, 15));
      issue_rt     = AW'($urandom_range(0, 15));
      issue_rd     = AW'($urandom_range(0, 15));
      step("rnd");
      for (int i = 0; i < int'(NS); i++) begin
        if (!src_valid[i] || last_g == i) begin
          if ($urandom_range(0, 1) == 1) set_src(i, 1'b1, AW'($urandom_range(0, 15)), $urandom);
          else src_valid[i] = 1'b0;
        end
      end
    end
    reset = 1'b0; issue_valid = 1'b0; src_valid = '0;
    step("drain0");
    step("drain1");

    for (int r = 0; r < int'(NUM_REGS); r++) check("rf", 64'(rf[r]), 64'(m_rf[r]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
